retire_checker: RTL and testbench

Synthesizable retirement checker for the MIPS cores: accepts up to LANES retired-instruction records per cycle from the DUT and buffers them in a circular FIFO. It compares them one per cycle against an expected stream from a reference-model port with a valid/ready handshake. It latches the first divergence and declares pass on the end-of-test syscall. It sits beside `top` in multi-issue and bring-up configurations, replacing per-cycle testbench comparison with a registered, stall-aware scoreboard.

---
 rtl/retire_checker_pkg.sv | 39 +++
 rtl/retire_checker_if.sv | 38 +++
 rtl/retire_checker_fifo.sv | 77 +++++++
 rtl/retire_checker.sv | 164 ++++++++++++++++
 tb/tb_retire_checker.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/retire_checker_pkg.sv
// retire_chk_pkg: shared types for the retirement checker.
// Record layout, FSM states, failure causes and write normalization.
package retire_chk_pkg;

  localparam int REC_XLEN = 32;
  localparam int REF_LATE_LIMIT = 256;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PASS,
    FAIL
  } state_t;

  typedef enum logic [1:0] {
    FC_NONE,
    FC_MISMATCH,
    FC_OVERFLOW,
    FC_REF_LATE
  } fail_cause_t;

  typedef struct packed {
    logic [REC_XLEN-1:0] pc;
    logic [REC_XLEN-1:0] instr;
    logic                wr_en;
    logic [4:0]          wr_idx;
    logic [REC_XLEN-1:0] wr_data;
    logic [REC_XLEN-1:0] v0;
  } retire_rec_t;

  // A write to r0 is architecturally invisible.
  function automatic logic norm_we(
    input logic       en,
    input logic [4:0] idx
  );
    return en && (idx != 5'd0);
  endfunction

endpackage

// File: rtl/retire_checker_if.sv
// retire_checker_if: DUT retire lanes plus reference-model stream.
// master drives retirements/expectations, slave is the checker.
interface retire_checker_if #(
  parameter int LANES = 1,
  parameter int XLEN  = 32
);
  logic [LANES-1:0]      dut_valid;
  logic [LANES*XLEN-1:0] dut_pc;
  logic [LANES*XLEN-1:0] dut_instr;
  logic [LANES-1:0]      dut_wr_en;
  logic [LANES*5-1:0]    dut_wr_idx;
  logic [LANES*XLEN-1:0] dut_wr_data;
  logic [LANES*XLEN-1:0] dut_v0;

  logic            ref_valid;
  logic            ref_ready;
  logic [XLEN-1:0] ref_pc;
  logic [XLEN-1:0] ref_instr;
  logic [XLEN-1:0] ref_wr_data;
  logic            ref_wr_en;
  logic [4:0]      ref_wr_idx;

  modport master (
    output dut_valid, dut_pc, dut_instr,
    output dut_wr_en, dut_wr_idx, dut_wr_data, dut_v0,
    output ref_valid, ref_pc, ref_instr,
    output ref_wr_data, ref_wr_en, ref_wr_idx,
    input  ref_ready
  );

  modport slave (
    input  dut_valid, dut_pc, dut_instr,
    input  dut_wr_en, dut_wr_idx, dut_wr_data, dut_v0,
    input  ref_valid, ref_pc, ref_instr,
    input  ref_wr_data, ref_wr_en, ref_wr_idx,
    output ref_ready
  );
endinterface

// File: rtl/retire_checker_fifo.sv
// retire_fifo: multi-lane push, single pop circular buffer.
// A push that would exceed DEPTH is rejected whole and flagged.
module retire_fifo
  import retire_chk_pkg::*;
#(
  parameter  int LANES = 1,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_push_en,
  input  logic [LANES-1:0]        i_valid,
  input  retire_rec_t [LANES-1:0] i_rec,
  input  logic                    i_pop,
  output retire_rec_t             o_head,
  output logic                    o_empty,
  output logic [CW-1:0]           o_occ,
  output logic [CW-1:0]           o_occ_next,
  output logic                    o_ovf
);

  retire_rec_t   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_occ;
  logic [CW-1:0] w_npush;
  logic [CW:0]   w_sum;
  logic          w_pop;
  logic          w_wr;

  // count retiring lanes this cycle
  always_comb begin
    w_npush = '0;
    for (int l = 0; l < LANES; l++)
      w_npush = w_npush + CW'(i_valid[l]);
  end

  assign o_empty = (r_occ == '0);
  assign w_pop   = i_pop && !o_empty;
  // pop frees its slot before the pushes land
  assign w_sum   = {1'b0, r_occ} + {1'b0, w_npush}
                 - (CW+1)'(w_pop);
  assign o_ovf   = i_push_en && (w_sum > (CW+1)'(DEPTH));
  assign w_wr    = i_push_en && !o_ovf;

  assign o_occ_next = w_wr ? w_sum[CW-1:0]
                           : r_occ - CW'(w_pop);
  assign o_occ  = r_occ;
  assign o_head = r_mem[r_rd_ptr];

  // store valid lanes in lane order from the write pointer
  always_ff @(posedge clk) begin
    if (w_wr) begin
      for (int l = 0; l < LANES; l++)
        if (i_valid[l])
          r_mem[r_wr_ptr + AW'(l)] <= i_rec[l];
    end
  end

  // pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_wr)
        r_wr_ptr <= r_wr_ptr + w_npush[AW-1:0];
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + AW'(1);
      r_occ <= o_occ_next;
    end
  end

endmodule

// File: rtl/retire_checker.sv
// retire_checker: registered, stall-aware retirement scoreboard.
// Buffers DUT retirements and checks them against a reference stream.
module retire_checker
  import retire_chk_pkg::*;
#(
  parameter int              LANES     = 1,
  parameter int              DEPTH     = 8,
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] END_INSTR = 32'h0000000c,
  parameter logic [XLEN-1:0] END_V0    = 32'h0000000a
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  retire_checker_if.slave  bus,
  output logic             stall_req,
  output logic             done,
  output logic             pass,
  output logic [1:0]       fail_cause,
  output logic [XLEN-1:0]  fail_pc,
  output logic [31:0]      retired_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int LW = $clog2(REF_LATE_LIMIT);

  state_t      r_state, w_state_next;
  fail_cause_t r_cause, w_cause_next;
  logic [XLEN-1:0] r_fail_pc, w_fail_pc_next;
  logic [31:0] r_count, w_count_next;
  logic [LW-1:0] r_late_cnt;
  logic        r_stall;

  retire_rec_t [LANES-1:0] w_rec;
  retire_rec_t   w_head;
  logic          w_empty;
  logic          w_ovf;
  logic [CW-1:0] w_occ;
  logic [CW-1:0] w_occ_next;

  logic w_run;
  logic w_hs;
  logic w_dut_we;
  logic w_ref_we;
  logic w_match;
  logic w_end;
  logic w_full;
  logic w_late_cond;
  logic w_late;

  // unpack flat lane buses into records
  always_comb begin
    w_rec = '0;
    for (int l = 0; l < LANES; l++) begin
      w_rec[l].pc      = bus.dut_pc[l*XLEN +: XLEN];
      w_rec[l].instr   = bus.dut_instr[l*XLEN +: XLEN];
      w_rec[l].wr_en   = bus.dut_wr_en[l];
      w_rec[l].wr_idx  = bus.dut_wr_idx[l*5 +: 5];
      w_rec[l].wr_data = bus.dut_wr_data[l*XLEN +: XLEN];
      w_rec[l].v0      = bus.dut_v0[l*XLEN +: XLEN];
    end
  end

  assign w_run = (r_state == RUN);

  retire_fifo #(
    .LANES (LANES),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push_en  (w_run),
    .i_valid    (bus.dut_valid),
    .i_rec      (w_rec),
    .i_pop      (w_hs),
    .o_head     (w_head),
    .o_empty    (w_empty),
    .o_occ      (w_occ),
    .o_occ_next (w_occ_next),
    .o_ovf      (w_ovf)
  );

  assign bus.ref_ready = w_run && !w_empty && bus.ref_valid;
  assign w_hs = bus.ref_ready;

  assign w_dut_we = norm_we(w_head.wr_en, w_head.wr_idx);
  assign w_ref_we = norm_we(bus.ref_wr_en, bus.ref_wr_idx);
  assign w_match  = (w_head.pc == bus.ref_pc)
                 && (w_head.instr == bus.ref_instr)
                 && (w_dut_we == w_ref_we)
                 && (!w_dut_we
                     || ((w_head.wr_idx == bus.ref_wr_idx)
                     && (w_head.wr_data == bus.ref_wr_data)));
  assign w_end = (w_head.instr == END_INSTR)
              && (w_head.v0 == END_V0);

  assign w_full      = (w_occ == CW'(DEPTH));
  assign w_late_cond = w_run && w_full && !bus.ref_valid;
  assign w_late      = w_late_cond
                    && (r_late_cnt == LW'(REF_LATE_LIMIT - 1));

  // verdict FSM: the popped record decides before overflow or starvation
  always_comb begin
    w_state_next   = r_state;
    w_cause_next   = r_cause;
    w_fail_pc_next = r_fail_pc;
    w_count_next   = r_count;
    unique case (r_state)
      IDLE: begin
        if (enable)
          w_state_next = RUN;
      end
      RUN: begin
        if (w_hs && !w_match) begin
          w_state_next   = FAIL;
          w_cause_next   = FC_MISMATCH;
          w_fail_pc_next = w_head.pc;
        end else begin
          if (w_hs)
            w_count_next = r_count + 32'd1;
          if (w_hs && w_end) begin
            w_state_next = PASS;
          end else if (w_ovf) begin
            w_state_next   = FAIL;
            w_cause_next   = FC_OVERFLOW;
            w_fail_pc_next = bus.dut_pc[XLEN-1:0];
          end else if (w_late) begin
            w_state_next   = FAIL;
            w_cause_next   = FC_REF_LATE;
            w_fail_pc_next = w_head.pc;
          end
        end
      end
      default: ;
    endcase
  end

  // state, verdict, counters and registered stall request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_cause    <= FC_NONE;
      r_fail_pc  <= '0;
      r_count    <= '0;
      r_late_cnt <= '0;
      r_stall    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cause    <= w_cause_next;
      r_fail_pc  <= w_fail_pc_next;
      r_count    <= w_count_next;
      r_late_cnt <= w_late_cond ? r_late_cnt + LW'(1) : '0;
      r_stall    <= (w_occ_next >= CW'(DEPTH - LANES));
    end
  end

  assign stall_req     = r_stall;
  assign done          = (r_state == PASS) || (r_state == FAIL);
  assign pass          = (r_state == PASS);
  assign fail_cause    = r_cause;
  assign fail_pc       = r_fail_pc;
  assign retired_count = r_count;

endmodule

// File: tb/tb_retire_checker.sv
// tb_retire_checker: directed scoreboard bench for retire_checker.
// Stimulus queues expected verdicts; a monitor checks them on done.
module tb_retire_checker;
  import retire_chk_pkg::*;

  localparam int LANES = 2;
  localparam int DEPTH = 8;
  localparam int XLEN  = 32;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        we;
    logic [4:0]  idx;
    logic [31:0] data;
    logic [31:0] v0;
  } rec_t;

  typedef struct {
    logic        pass;
    logic [1:0]  cause;
    logic [31:0] pc;
    logic [31:0] cnt;
    bit          lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic stall_req, done, pass;
  logic [1:0]  fail_cause;
  logic [31:0] fail_pc, retired_count;

  retire_checker_if #(.LANES(LANES), .XLEN(XLEN)) bus();

  retire_checker #(
    .LANES (LANES),
    .DEPTH (DEPTH),
    .XLEN  (XLEN)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .bus           (bus),
    .stall_req     (stall_req),
    .done          (done),
    .pass          (pass),
    .fail_cause    (fail_cause),
    .fail_pc       (fail_pc),
    .retired_count (retired_count)
  );

  always #5 clk = ~clk;

  rec_t ref_q[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_hs = -100;
  bit   hs_pend = 0;
  bit   ref_en = 0;
  bit   seen = 0;
  exp_t e;
  rec_t d, r;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic rec_t mk(input int i, input bit last);
    rec_t x;
    x.pc    = 32'h0040_0000 + 32'(4 * i);
    x.instr = last ? 32'h0000_000c : 32'h2002_0000 + 32'(i);
    x.we    = 1'b1;
    x.idx   = 5'(i % 31 + 1);
    x.data  = 32'(i * 3);
    x.v0    = last ? 32'h0000_000a : 32'h0;
    return x;
  endfunction

  function automatic exp_t mk_exp(input logic p, input logic [1:0] c,
                                  input logic [31:0] pc,
                                  input logic [31:0] n, input bit lat);
    exp_t x;
    x.pass = p; x.cause = c; x.pc = pc; x.cnt = n; x.lat = lat;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_lane(input int l, input rec_t x);
    bus.dut_pc[l*32 +: 32]      = x.pc;
    bus.dut_instr[l*32 +: 32]   = x.instr;
    bus.dut_wr_en[l]            = x.we;
    bus.dut_wr_idx[l*5 +: 5]    = x.idx;
    bus.dut_wr_data[l*32 +: 32] = x.data;
    bus.dut_v0[l*32 +: 32]      = x.v0;
  endtask

  task automatic drive_ref();
    if (ref_en && ref_q.size() > 0) begin
      bus.ref_valid   = 1'b1;
      bus.ref_pc      = ref_q[0].pc;
      bus.ref_instr   = ref_q[0].instr;
      bus.ref_wr_en   = ref_q[0].we;
      bus.ref_wr_idx  = ref_q[0].idx;
      bus.ref_wr_data = ref_q[0].data;
    end else begin
      bus.ref_valid = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (hs_pend) begin
      hs_pend = 0;
      if (ref_q.size() > 0) void'(ref_q.pop_front());
    end
    drive_ref();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    enable = 1'b0;
    bus.dut_valid = '0;
    ref_en = 0;
    ref_q.delete();
    hs_pend = 0;
    drive_ref();
    step();
    step();
    reset = 1'b1;
    step();
    enable = 1'b1;
    step();
  endtask

  task automatic push1(input rec_t a);
    set_lane(0, a);
    bus.dut_valid = 2'b01;
    step();
    bus.dut_valid = '0;
  endtask

  task automatic push2(input rec_t a, input rec_t b);
    set_lane(0, a);
    set_lane(1, b);
    bus.dut_valid = 2'b11;
    step();
    bus.dut_valid = '0;
  endtask

  task automatic wait_done(input int n);
    for (int k = 0; k < n && !done; k++) step();
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got 0 expected 1");
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    step();
  endtask

  // monitor: track handshakes, check verdict when done rises
  always @(negedge clk) begin
    if (bus.ref_valid && bus.ref_ready) begin
      hs_pend = 1;
      last_hs = cyc;
    end
    if (!done) begin
      seen = 0;
    end else if (!seen) begin
      seen = 1;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got 1 expected 0");
      end else begin
        e = exp_q.pop_front();
        chk("pass", 32'(pass), 32'(e.pass));
        chk("fail_cause", 32'(fail_cause), 32'(e.cause));
        chk("fail_pc", fail_pc, e.pc);
        chk("retired_count", retired_count, e.cnt);
        if (e.lat)
          chk("verdict_latency", 32'(cyc - last_hs), 32'd1);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.dut_valid = '0;
    bus.dut_pc = '0;
    bus.dut_instr = '0;
    bus.dut_wr_en = '0;
    bus.dut_wr_idx = '0;
    bus.dut_wr_data = '0;
    bus.dut_v0 = '0;
    bus.ref_valid = 1'b0;
    bus.ref_pc = '0;
    bus.ref_instr = '0;
    bus.ref_wr_en = 1'b0;
    bus.ref_wr_idx = '0;
    bus.ref_wr_data = '0;
    #1;
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_cause", 32'(fail_cause), 0);
    chk("rst_fail_pc", fail_pc, 0);
    chk("rst_count", retired_count, 0);
    chk("rst_stall", 32'(stall_req), 0);
    chk("rst_ref_ready", 32'(bus.ref_ready), 0);

    // ten records, last is the exit syscall
    do_reset();
    ref_en = 1;
    for (int i = 0; i < 10; i++) ref_q.push_back(mk(i, i == 9));
    drive_ref();
    exp_q.push_back(mk_exp(1'b1, 2'd0, 32'h0, 32'd10, 1'b1));
    for (int i = 0; i < 10; i++) push1(mk(i, i == 9));
    wait_done(50);

    // fourth record write data differs
    do_reset();
    ref_en = 1;
    for (int i = 0; i < 6; i++) begin
      d = mk(20 + i, 1'b0);
      r = d;
      if (i == 3) begin
        d.data = 32'h6;
        r.data = 32'h5;
      end
      ref_q.push_back(r);
    end
    drive_ref();
    d = mk(23, 1'b0);
    exp_q.push_back(mk_exp(1'b0, 2'd1, d.pc, 32'd3, 1'b1));
    for (int i = 0; i < 6; i++) begin
      d = mk(20 + i, 1'b0);
      if (i == 3) d.data = 32'h6;
      push1(d);
    end
    wait_done(50);
    for (int k = 0; k < 3; k++) begin
      chk("no_pop_after_fail", 32'(bus.ref_ready), 0);
      step();
    end
    chk("count_frozen", retired_count, 32'd3);

    // r0 write on DUT matches ref no-write
    do_reset();
    ref_en = 1;
    r = mk(40, 1'b0);
    r.we = 1'b0;
    r.idx = 5'd7;
    r.data = 32'h1234;
    ref_q.push_back(r);
    ref_q.push_back(mk(41, 1'b1));
    drive_ref();
    exp_q.push_back(mk_exp(1'b1, 2'd0, 32'h0, 32'd2, 1'b1));
    d = mk(40, 1'b0);
    d.idx = 5'd0;
    d.data = 32'hdead;
    push1(d);
    push1(mk(41, 1'b1));
    wait_done(50);

    // two lanes per cycle, no ref: stall then overflow
    do_reset();
    d = mk(58, 1'b0);
    exp_q.push_back(mk_exp(1'b0, 2'd2, d.pc, 32'd0, 1'b0));
    for (int c = 0; c < 5; c++) begin
      push2(mk(50 + 2 * c, 1'b0), mk(51 + 2 * c, 1'b0));
      if (c < 4)
        chk($sformatf("stall_occ%0d", 2 * c + 2),
            32'(stall_req), (c >= 2) ? 32'd1 : 32'd0);
    end
    wait_done(5);

    // full FIFO starved 255 cycles, then ref arrives
    do_reset();
    for (int i = 0; i < 8; i++) ref_q.push_back(mk(60 + i, i == 7));
    for (int c = 0; c < 4; c++)
      push2(mk(60 + 2 * c, 1'b0), mk(61 + 2 * c, c == 3));
    for (int k = 0; k < 255; k++) step();
    chk("late_255_no_fail", 32'(done), 0);
    exp_q.push_back(mk_exp(1'b1, 2'd0, 32'h0, 32'd8, 1'b1));
    ref_en = 1;
    drive_ref();
    wait_done(50);

    // full FIFO starved 256 cycles
    do_reset();
    d = mk(70, 1'b0);
    exp_q.push_back(mk_exp(1'b0, 2'd3, d.pc, 32'd0, 1'b0));
    for (int c = 0; c < 4; c++)
      push2(mk(70 + 2 * c, 1'b0), mk(71 + 2 * c, 1'b0));
    for (int k = 0; k < 255; k++) step();
    chk("late_255_pending", 32'(done), 0);
    wait_done(5);

    // reset mid-run with five buffered entries
    do_reset();
    ref_en = 1;
    for (int i = 0; i < 3; i++) ref_q.push_back(mk(80 + i, 1'b0));
    drive_ref();
    for (int i = 0; i < 3; i++) push1(mk(80 + i, 1'b0));
    for (int k = 0; k < 4; k++) step();
    chk("pre_reset_count", retired_count, 32'd3);
    ref_en = 0;
    drive_ref();
    push2(mk(90, 1'b0), mk(91, 1'b0));
    push2(mk(92, 1'b0), mk(93, 1'b0));
    push1(mk(94, 1'b0));
    bus.ref_valid = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk("async_count", retired_count, 0);
    chk("async_done", 32'(done), 0);
    chk("async_stall", 32'(stall_req), 0);
    chk("async_ref_ready", 32'(bus.ref_ready), 0);
    chk("async_state", 32'(dut.r_state), 32'(IDLE));
    bus.ref_valid = 1'b0;
    do_reset();
    ref_en = 1;
    for (int i = 0; i < 3; i++) ref_q.push_back(mk(100 + i, i == 2));
    drive_ref();
    exp_q.push_back(mk_exp(1'b1, 2'd0, 32'h0, 32'd3, 1'b1));
    for (int i = 0; i < 3; i++) push1(mk(100 + i, i == 2));
    wait_done(50);

    chk("exp_queue_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
